// File: rtl/rat_io_pkg.sv
// Shared definitions for the RAT port-bus responder: default port IDs
// and the layout of the TX status byte.
package rat_io_pkg;

    localparam logic [7:0] LED_ID_DEF  = 8'h40;
    localparam logic [7:0] TX_ID_DEF   = 8'h41;
    localparam logic [7:0] MASK_ID_DEF = 8'h42;
    localparam logic [7:0] ACK_ID_DEF  = 8'h43;
    localparam logic [7:0] BTN_ID_DEF  = 8'h44;
    localparam logic [7:0] SW_ID_DEF   = 8'hFF;

    localparam int unsigned STAT_OVF   = 7;
    localparam int unsigned STAT_FULL  = 6;
    localparam int unsigned STAT_EMPTY = 5;

    // Assemble the TX status byte {overflow, full, empty, count[4:0]}
    function automatic logic [7:0] pack_status(input logic       ovf,
                                               input logic       full,
                                               input logic       empty,
                                               input logic [4:0] cnt);
        logic [7:0] s;
        s             = {3'b000, cnt};
        s[STAT_OVF]   = ovf;
        s[STAT_FULL]  = full;
        s[STAT_EMPTY] = empty;
        return s;
    endfunction

endpackage

// File: rtl/io_byte_fifo.sv
// Byte-wide circular FIFO. A push into a full FIFO is only accepted when
// a pop frees a slot in the same cycle; otherwise it is dropped and
// overflow_pulse fires for one cycle.
module io_byte_fifo #(
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          push,
    input  logic [7:0]                    din,
    input  logic                          pop,
    output logic [7:0]                    dout,
    output logic [$clog2(FIFO_DEPTH):0]   count,
    output logic                          full,
    output logic                          empty,
    output logic                          overflow_pulse
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [7:0]    r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          w_pop;
    logic          w_push;

    assign full           = (r_count == CW'(FIFO_DEPTH));
    assign empty          = (r_count == '0);
    assign w_pop          = pop & ~empty;
    assign w_push         = push & (~full | w_pop);
    assign overflow_pulse = push & full & ~w_pop;
    assign dout           = r_mem[r_rd_ptr];
    assign count          = r_count;

    // Pointer and occupancy tracking; pointers wrap naturally at power-of-2 depth
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage write; contents need no reset because count gates visibility
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= din;
    end

endmodule

// File: rtl/rat_io_responder.sv
// Peripheral side of the RAT MCU port bus: write decode, LED register,
// TX FIFO, input synchronizers, button-edge interrupts and read mux.
module rat_io_responder
    import rat_io_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter logic [7:0]  LED_ID     = LED_ID_DEF,
    parameter logic [7:0]  TX_ID      = TX_ID_DEF,
    parameter logic [7:0]  MASK_ID    = MASK_ID_DEF,
    parameter logic [7:0]  ACK_ID     = ACK_ID_DEF,
    parameter logic [7:0]  SW_ID      = SW_ID_DEF,
    parameter logic [7:0]  BTN_ID     = BTN_ID_DEF
) (
    input  logic       clk,
    input  logic       RESET_N,
    input  logic [7:0] PORT_ID,
    input  logic [7:0] OUT_PORT,
    input  logic       IO_STRB,
    output logic [7:0] IN_PORT,
    output logic       INTV,
    input  logic [7:0] SWITCHES,
    input  logic [3:0] BUTTONS,
    output logic [7:0] LEDS,
    output logic [7:0] TX_DATA,
    output logic       TX_VALID,
    input  logic       TX_READY
);

    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

    logic [7:0]    r_sw_s1, r_sw_s2;
    logic [3:0]    r_btn_s1, r_btn_s2, r_btn_prev;
    logic [7:0]    r_leds;
    logic [3:0]    r_mask, r_pend;
    logic          r_ovf, r_intv;

    logic          w_wr_led, w_wr_tx, w_wr_mask, w_wr_ack;
    logic [3:0]    w_btn_rise, w_ack_clr;
    logic [CW-1:0] w_count;
    logic          w_full, w_empty, w_ovf_pulse;

    assign w_wr_led   = IO_STRB && (PORT_ID == LED_ID);
    assign w_wr_tx    = IO_STRB && (PORT_ID == TX_ID);
    assign w_wr_mask  = IO_STRB && (PORT_ID == MASK_ID);
    assign w_wr_ack   = IO_STRB && (PORT_ID == ACK_ID);
    assign w_btn_rise = r_btn_s2 & ~r_btn_prev;
    assign w_ack_clr  = w_wr_ack ? OUT_PORT[3:0] : 4'b0000;

    io_byte_fifo #(
        .FIFO_DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk           (clk),
        .rst_n         (RESET_N),
        .push          (w_wr_tx),
        .din           (OUT_PORT),
        .pop           (TX_READY),
        .dout          (TX_DATA),
        .count         (w_count),
        .full          (w_full),
        .empty         (w_empty),
        .overflow_pulse(w_ovf_pulse)
    );

    assign TX_VALID = ~w_empty;
    assign LEDS     = r_leds;
    assign INTV     = r_intv;

    // Two-stage synchronizers plus button history for edge detection
    always_ff @(posedge clk or negedge RESET_N) begin
        if (!RESET_N) begin
            r_sw_s1    <= '0;
            r_sw_s2    <= '0;
            r_btn_s1   <= '0;
            r_btn_s2   <= '0;
            r_btn_prev <= '0;
        end else begin
            r_sw_s1    <= SWITCHES;
            r_sw_s2    <= r_sw_s1;
            r_btn_s1   <= BUTTONS;
            r_btn_s2   <= r_btn_s1;
            r_btn_prev <= r_btn_s2;
        end
    end

    // Write-side registers, pending/overflow flags and registered interrupt level
    always_ff @(posedge clk or negedge RESET_N) begin
        if (!RESET_N) begin
            r_leds <= '0;
            r_mask <= '0;
            r_pend <= '0;
            r_ovf  <= 1'b0;
            r_intv <= 1'b0;
        end else begin
            if (w_wr_led)  r_leds <= OUT_PORT;
            if (w_wr_mask) r_mask <= OUT_PORT[3:0];
            // OR-ing the new edges after the clear lets a set win a same-cycle ACK
            r_pend <= (r_pend & ~w_ack_clr) | w_btn_rise;
            if (w_ovf_pulse)                  r_ovf <= 1'b1;
            else if (w_wr_ack && OUT_PORT[7]) r_ovf <= 1'b0;
            r_intv <= |(r_pend & r_mask);
        end
    end

    // Zero-latency read mux over registered sources
    always_comb begin
        IN_PORT = 8'h00;
        if (PORT_ID == SW_ID)        IN_PORT = r_sw_s2;
        else if (PORT_ID == BTN_ID)  IN_PORT = {4'b0000, r_btn_s2};
        else if (PORT_ID == TX_ID)   IN_PORT = pack_status(r_ovf, w_full, w_empty, 5'(w_count));
        else if (PORT_ID == MASK_ID) IN_PORT = {4'b0000, r_mask};
        else if (PORT_ID == ACK_ID)  IN_PORT = {4'b0000, r_pend};
    end

endmodule

// File: tb/tb_rat_io_responder.sv
// Self-checking bench for rat_io_responder: directed scenarios followed by
// randomized bus traffic, all checked against a queue-based reference model.
module tb_rat_io_responder;

    localparam int unsigned D = 4;

    logic       clk = 1'b0;
    logic       RESET_N = 1'b0;
    logic [7:0] PORT_ID = 8'h00;
    logic [7:0] OUT_PORT = 8'h00;
    logic       IO_STRB = 1'b0;
    logic [7:0] IN_PORT;
    logic       INTV;
    logic [7:0] SWITCHES = 8'h00;
    logic [3:0] BUTTONS = 4'h0;
    logic [7:0] LEDS;
    logic [7:0] TX_DATA;
    logic       TX_VALID;
    logic       TX_READY = 1'b0;

    rat_io_responder #(
        .FIFO_DEPTH(D)
    ) dut (
        .clk     (clk),
        .RESET_N (RESET_N),
        .PORT_ID (PORT_ID),
        .OUT_PORT(OUT_PORT),
        .IO_STRB (IO_STRB),
        .IN_PORT (IN_PORT),
        .INTV    (INTV),
        .SWITCHES(SWITCHES),
        .BUTTONS (BUTTONS),
        .LEDS    (LEDS),
        .TX_DATA (TX_DATA),
        .TX_VALID(TX_VALID),
        .TX_READY(TX_READY)
    );

    always #5 clk = ~clk;

    int unsigned n_vec  = 0;
    int unsigned n_miss = 0;

    // Reference model state
    logic [7:0] m_leds, m_sw1, m_sw2;
    logic [3:0] m_mask, m_pend, m_b1, m_b2, m_bp;
    logic       m_ovf, m_intv;
    logic [7:0] m_q[$];

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic m_reset();
        m_leds = 0; m_sw1 = 0; m_sw2 = 0;
        m_mask = 0; m_pend = 0; m_b1 = 0; m_b2 = 0; m_bp = 0;
        m_ovf = 0; m_intv = 0;
        m_q.delete();
    endtask

    function automatic logic [7:0] m_read(input logic [7:0] pid);
        int unsigned sz = m_q.size();
        case (pid)
            8'hFF:   return m_sw2;
            8'h44:   return {4'h0, m_b2};
            8'h41:   return {m_ovf, sz == D, sz == 0, 5'(sz)};
            8'h42:   return {4'h0, m_mask};
            8'h43:   return {4'h0, m_pend};
            default: return 8'h00;
        endcase
    endfunction

    // Advance the model by one clock using the inputs present at the edge
    task automatic m_edge();
        int unsigned sz  = m_q.size();
        logic        pop = (sz != 0) && TX_READY;
        logic [3:0]  rise = m_b2 & ~m_bp;
        logic [3:0]  clr  = 4'h0;
        m_intv = |(m_pend & m_mask);
        if (pop) void'(m_q.pop_front());
        if (IO_STRB) begin
            case (PORT_ID)
                8'h40: m_leds = OUT_PORT;
                8'h41: if (sz == D && !pop) m_ovf = 1'b1; else m_q.push_back(OUT_PORT);
                8'h42: m_mask = OUT_PORT[3:0];
                8'h43: begin clr = OUT_PORT[3:0]; if (OUT_PORT[7]) m_ovf = 1'b0; end
                default: ;
            endcase
        end
        m_pend = (m_pend & ~clr) | rise;
        m_bp = m_b2; m_b2 = m_b1; m_b1 = BUTTONS;
        m_sw2 = m_sw1; m_sw1 = SWITCHES;
    endtask

    // One bus cycle: check the read mux, clock, then check registered outputs
    task automatic step(input logic [7:0] pid, input logic [7:0] od, input logic strb);
        PORT_ID = pid; OUT_PORT = od; IO_STRB = strb;
        #1 chk("read_mux", IN_PORT, m_read(pid));
        @(posedge clk);
        m_edge();
        #1;
        chk("leds", LEDS, m_leds);
        chk("tx_valid", {7'b0, TX_VALID}, {7'b0, m_q.size() != 0});
        if (m_q.size() != 0) chk("tx_data", TX_DATA, m_q[0]);
        chk("intv", {7'b0, INTV}, {7'b0, m_intv});
    endtask

    task automatic idle(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) step(8'h00, 8'h00, 1'b0);
    endtask

    task automatic peek(input string tag, input logic [7:0] pid, input logic [7:0] exp);
        PORT_ID = pid; IO_STRB = 1'b0;
        #1 chk(tag, IN_PORT, exp);
    endtask

    initial begin
        m_reset();
        #12 RESET_N = 1'b1;
        @(posedge clk); #1;

        // Load two bytes, then reset asynchronously mid-cycle
        TX_READY = 1'b0;
        step(8'h41, 8'hDE, 1'b1);
        step(8'h41, 8'hAD, 1'b1);
        step(8'h40, 8'h5A, 1'b1);
        IO_STRB = 1'b0;
        #2 RESET_N = 1'b0;
        m_reset();
        #1;
        chk("rst_leds", LEDS, 8'h00);
        chk("rst_valid", {7'b0, TX_VALID}, 8'h00);
        chk("rst_intv", {7'b0, INTV}, 8'h00);
        peek("rst_status", 8'h41, 8'h20);
        @(posedge clk); #1 RESET_N = 1'b1;

        // LED write, then a write to an unmapped ID
        step(8'h40, 8'hA5, 1'b1);
        chk("led_a5", LEDS, 8'hA5);
        step(8'h50, 8'h33, 1'b1);
        chk("led_hold", LEDS, 8'hA5);

        // Overfill with consumer stalled, then drain
        for (int unsigned i = 1; i <= 5; i++) step(8'h41, 8'(i * 8'h11), 1'b1);
        peek("stat_full_ovf", 8'h41, 8'hC4);
        idle(2);
        chk("head_stable", TX_DATA, 8'h11);
        TX_READY = 1'b1;
        idle(5);
        peek("stat_drained", 8'h41, 8'hA0);
        step(8'h43, 8'h80, 1'b1);
        peek("stat_ovf_clr", 8'h41, 8'h20);

        // Fill, then push while popping: accepted with no overflow
        TX_READY = 1'b0;
        for (int unsigned i = 1; i <= 4; i++) step(8'h41, 8'(i), 1'b1);
        TX_READY = 1'b1;
        step(8'h41, 8'h66, 1'b1);
        peek("full_pushpop", 8'h41, 8'h44);
        idle(5);

        // Button interrupts with mask bit 0
        step(8'h42, 8'h01, 1'b1);
        BUTTONS = 4'h1; idle(2); BUTTONS = 4'h0; idle(2);
        chk("intv_b0", {7'b0, INTV}, 8'h01);
        peek("pend_01", 8'h43, 8'h01);
        BUTTONS = 4'h2; idle(2); BUTTONS = 4'h0; idle(2);
        peek("pend_03", 8'h43, 8'h03);
        chk("intv_hold", {7'b0, INTV}, 8'h01);
        step(8'h43, 8'h03, 1'b1);
        idle(3);
        // Edge on button 0 reaches the detector exactly when the ACK lands
        BUTTONS = 4'h1;
        step(8'h00, 8'h00, 1'b0);
        step(8'h00, 8'h00, 1'b0);
        step(8'h43, 8'h01, 1'b1);
        peek("set_wins", 8'h43, 8'h01);
        BUTTONS = 4'h0;
        step(8'h43, 8'h0F, 1'b1);

        // Switch change mid-cycle; masked buttons never interrupt
        step(8'h42, 8'h00, 1'b1);
        #3 SWITCHES = 8'h3C;
        step(8'hFF, 8'h00, 1'b0);
        step(8'hFF, 8'h00, 1'b0);
        peek("sw_new", 8'hFF, 8'h3C);
        for (int unsigned i = 0; i < 6; i++) begin
            BUTTONS = 4'(i);
            step(8'h44, 8'h00, 1'b0);
        end
        chk("masked_intv", {7'b0, INTV}, 8'h00);

        // Randomized traffic
        for (int unsigned i = 0; i < 600; i++) begin
            logic [7:0] pid;
            case ($urandom_range(0, 7))
                0: pid = 8'h40;
                1, 2: pid = 8'h41;
                3: pid = 8'h42;
                4: pid = 8'h43;
                5: pid = 8'h44;
                6: pid = 8'hFF;
                default: pid = 8'($urandom);
            endcase
            TX_READY = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 3) == 0) BUTTONS = 4'($urandom);
            if ($urandom_range(0, 7) == 0) SWITCHES = 8'($urandom);
            step(pid, 8'($urandom), 1'($urandom_range(0, 1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/rat_io_responder.md
Name: rat_io_responder

Overview:
- Peripheral-side responder for the RAT MCU port bus. It decodes PORT_ID, accepts OUT writes qualified by IO_STRB, and returns IN_PORT read data.
- Provides an LED output register, a byte TX FIFO drained by a downstream valid/ready consumer, and button-edge interrupt logic that drives the MCU INTV line.
- Sits at top level beside the MCU, as the other end of its OUT_PORT/PORT_ID/IO_STRB/IN_PORT/INTV interface.

Parameters:
- FIFO_DEPTH, 4: TX FIFO entries; power of 2, range 2..16.
- LED_ID, 8'h40: write port for the LED register.
- TX_ID, 8'h41: write pushes the TX FIFO; read returns FIFO status.
- MASK_ID, 8'h42: read/write interrupt mask.
- ACK_ID, 8'h43: write-1-to-clear pending; read returns the pending register.
- SW_ID, 8'hFF: read synchronized switches.
- BTN_ID, 8'h44: read synchronized buttons.

Ports:
- clk  in  1  system clock, shared with the MCU.
- RESET_N  in  1  asynchronous, active-low reset.
- PORT_ID  in  8  port address from the MCU.
- OUT_PORT  in  8  write data from the MCU.
- IO_STRB  in  1  write strobe; each high cycle is one write.
- IN_PORT  out  8  read data to the MCU.
- INTV  out  1  interrupt request to the MCU.
- SWITCHES  in  8  asynchronous board switches.
- BUTTONS  in  4  asynchronous board buttons.
- LEDS  out  8  LED register.
- TX_DATA  out  8  FIFO head byte.
- TX_VALID  out  1  FIFO not empty.
- TX_READY  in  1  consumer accepts the head byte.

Behaviour:
- Reset: clk is the only clock. RESET_N low asynchronously clears the following:
  - LEDS=0, mask=0, pending=0, overflow=0.
  - FIFO pointers and count=0, so TX_VALID=0.
  - Both synchronizer stages and the button history flops, so there are no false edges after reset.
- Reset mid-operation: any FIFO contents are discarded.
- Writes (only when IO_STRB=1 at a rising clk edge):
  - LED_ID: LEDS<=OUT_PORT, visible the next cycle.
  - TX_ID: push OUT_PORT.
  - MASK_ID: mask[3:0]<=OUT_PORT[3:0].
  - ACK_ID: pending<=pending & ~OUT_PORT[3:0]; if OUT_PORT[7]=1, overflow<=0.
  - Any other ID: ignored.
- Reads:
  - IN_PORT is a purely combinational mux on PORT_ID over registered sources, with zero latency, so the MCU samples it at its execute edge.
  - SW_ID returns sw_sync.
  - BTN_ID returns {4'b0, btn_sync}.
  - TX_ID returns {overflow, full, empty, count[4:0]}.
  - MASK_ID returns {4'b0, mask}.
  - ACK_ID returns {4'b0, pending}.
  - Unmapped IDs return 8'h00.
  - Reads have no side effects.
- Synchronizers: SWITCHES and BUTTONS each pass through a 2-flop synchronizer. A third flop on the buttons holds the previous value for edge detection.
- Interrupt:
  - Button rising edge (sync=1, prev=0) sets pending[i] one cycle after the edge reaches the second sync flop.
  - If a set and an ACK clear hit the same bit in the same cycle, the set wins.
  - INTV = |(pending & mask), registered, so it updates one cycle after pending/mask change.
  - INTV stays high until acknowledged or masked; it is level, not a pulse.
- TX FIFO:
  - Circular buffer with wr_ptr, rd_ptr, and count of width clog2(FIFO_DEPTH)+1.
  - TX_DATA = mem[rd_ptr]. TX_VALID = (count!=0).
  - Pop occurs when TX_VALID && TX_READY.
  - TX_DATA must stay stable while TX_VALID=1 and TX_READY=0.
  - Pointers wrap modulo FIFO_DEPTH.
- FIFO boundary conditions:
  - Push when full with no pop: the byte is dropped, overflow<=1 (sticky), and count is unchanged.
  - Push when full with a simultaneous pop: the push is accepted and count is unchanged.
  - Push when empty: no pop is possible that cycle; count becomes 1 and TX_VALID rises the next cycle.
  - Push and pop together when neither full nor empty: count is unchanged.
- No internal state machine beyond the FIFO and flags. All state updates occur on the rising clk edge.

Decomposition:
- Shared package rat_io_pkg holds the default port-ID localparams and the status-byte bit positions (OVF=7, FULL=6, EMPTY=5).
- One natural sub-module, io_byte_fifo, parameterized by FIFO_DEPTH:
  - Inputs: push, din, pop.
  - Outputs: dout, count, full, empty, overflow_pulse.
- The top level holds the decode, synchronizers, interrupt logic and read mux.

Test Plan:
- Reset with RESET_N=0 mid-cycle, FIFO holding 2 bytes -> LEDS=0, TX_VALID=0, INTV=0 immediately; read of TX_ID returns 8'h20.
- IO_STRB=1, PORT_ID=8'h40, OUT_PORT=8'hA5 for one cycle -> LEDS=8'hA5 next cycle; a write with PORT_ID=8'h50 leaves LEDS unchanged.
- TX_READY=0, push 8'h11,22,33,44,55 -> status reads 8'hC4, head stays 8'h11; raise TX_READY -> bytes 11,22,33,44 pop in order, then TX_VALID=0 and status=8'hA0; ACK write 8'h80 -> status=8'h20.
- FIFO full, TX_READY=1, push 8'h66 the same cycle -> count stays 4, no overflow; drain sequence ends with 8'h66.
- Mask=8'h01, pulse BUTTONS[0] -> INTV=1 within 4 cycles, ACK_ID reads 8'h01; pulse BUTTONS[1] -> pending=8'h03, INTV stays 1; ACK write 8'h01 while BUTTONS[0] re-edges the same cycle -> pending[0] stays 1.
- SWITCHES=8'h3C changed asynchronously -> PORT_ID=8'hFF read returns 8'h3C after 2 edges and the old value before that; INTV remains 0 with mask=0 regardless of button activity.
